// File: rtl/cache_opr_seq_if.sv
// cache_opr_seq_if: request/cancel/completion inputs and enable/status outputs of the cache operation sequencer.
interface cache_opr_seq_if #(
    parameter int NUM_OPR = 8
);
    localparam int SW = $clog2(NUM_OPR) + 1;
    logic               valid;
    logic               abort;
    logic               opr_finished;
    logic [NUM_OPR-1:0] opr_en;
    logic [SW-1:0]      stage;
    logic               busy;
    logic               done;
    logic               timeout_err;
    modport master (
        output valid, abort, opr_finished,
        input  opr_en, stage, busy, done, timeout_err
    );
    modport slave (
        input  valid, abort, opr_finished,
        output opr_en, stage, busy, done, timeout_err
    );
endinterface

// File: rtl/cache_opr_seq.sv
// cache_opr_seq: steps NUM_OPR operation enables one stage every STAGE_CYCLES,
// then waits for opr_finished with an optional timeout; all outputs registered.
module cache_opr_seq #(
    parameter int NUM_OPR      = 8,
    parameter int STAGE_CYCLES = 8,
    parameter int THERMO       = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rstb,
    cache_opr_seq_if.slave  bus
);
    localparam int SW = $clog2(NUM_OPR) + 1;
    localparam int TW = $clog2(STAGE_CYCLES > TIMEOUT ? STAGE_CYCLES : TIMEOUT) + 1;
    localparam logic [TW-1:0] SC_LAST    = TW'(STAGE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(NUM_OPR - 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_FIN} state_t;

    state_t             state;
    logic [SW-1:0]      stage;
    logic [TW-1:0]      timer;
    logic [NUM_OPR-1:0] opr_en;
    logic               busy, done, timeout_err;
    logic               fin_hit, tmo_hit, to_idle;

    function automatic logic [NUM_OPR-1:0] en_of(input logic [SW-1:0] s);
        for (int i = 0; i < NUM_OPR; i++)
            en_of[i] = (THERMO != 0) ? (i <= int'(s)) : (i == int'(s));
    endfunction

    // Completion beats timeout; abort beats both and suppresses any pulse.
    assign fin_hit = state == WAIT_FIN && bus.opr_finished;
    assign tmo_hit = state == WAIT_FIN && TIMEOUT != 0 && timer == TO_LAST;
    assign to_idle = bus.abort || fin_hit || tmo_hit;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            stage       <= '0;
            timer       <= '0;
            opr_en      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else if (to_idle) begin
            state       <= IDLE;
            stage       <= '0;
            timer       <= '0;
            opr_en      <= '0;
            busy        <= 1'b0;
            done        <= !bus.abort && fin_hit;
            timeout_err <= !bus.abort && !fin_hit;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: if (bus.valid) begin
                    state  <= RUN;
                    stage  <= '0;
                    timer  <= '0;
                    opr_en <= en_of('0);
                    busy   <= 1'b1;
                end
                RUN: if (timer == SC_LAST) begin
                    timer <= '0;
                    if (stage < STAGE_LAST) begin
                        stage  <= stage + 1'b1;
                        opr_en <= en_of(stage + 1'b1);
                    end else begin
                        state <= WAIT_FIN;
                    end
                end else begin
                    timer <= timer + 1'b1;
                end
                // Saturate rather than wrap when the timeout is disabled.
                WAIT_FIN: timer <= &timer ? timer : timer + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.opr_en      = opr_en;
    assign bus.stage       = stage;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_cache_opr_seq.sv
// tb_cache_opr_seq: directed checks of a thermometer and a one-hot sequencer driven in lockstep.
module tb_cache_opr_seq;
    logic clk = 1'b0;
    logic rstb = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    cache_opr_seq_if #(.NUM_OPR(8)) bt ();
    cache_opr_seq_if #(.NUM_OPR(8)) bo ();

    cache_opr_seq #(.NUM_OPR(8), .STAGE_CYCLES(8), .THERMO(1), .TIMEOUT(16)) dut_t (
        .clk(clk), .rstb(rstb), .bus(bt)
    );
    cache_opr_seq #(.NUM_OPR(8), .STAGE_CYCLES(8), .THERMO(0), .TIMEOUT(16)) dut_o (
        .clk(clk), .rstb(rstb), .bus(bo)
    );

    task automatic drive(input logic v, input logic a, input logic f);
        bt.valid = v; bt.abort = a; bt.opr_finished = f;
        bo.valid = v; bo.abort = a; bo.opr_finished = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start();
        drive(1'b1, 1'b0, 1'b0);
        cyc = 0;
        tick();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    function automatic int stg(input int c);
        int s;
        s = (c - 1) / 8;
        return s > 7 ? 7 : s;
    endfunction

    function automatic logic [7:0] exp_th(input int c);
        logic [7:0] ones;
        ones = 8'hFF;
        return ones >> (7 - stg(c));
    endfunction

    function automatic logic [7:0] exp_oh(input int c);
        logic [7:0] one;
        one = 8'h01;
        return one << stg(c);
    endfunction

    task automatic test_reset();
        rstb = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #2;
        checks++;
        if (bt.opr_en !== 8'h00 || bt.stage !== 4'd0 || bt.busy !== 1'b0 || bt.done !== 1'b0 || bt.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: en=%h stage=%0d busy=%b done=%b terr=%b, want 00/0/0/0/0", bt.opr_en, bt.stage, bt.busy, bt.done, bt.timeout_err);
        end
        @(negedge clk);
        rstb = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (bt.busy !== 1'b0 || bo.opr_en !== 8'h00) begin
            failures++;
            $display("FAIL reset_idle_hold: busy=%b en=%h, want 0/00", bt.busy, bo.opr_en);
        end
    endtask

    task automatic test_full_seq();
        start();
        repeat (70) begin
            checks++;
            if (bt.opr_en !== exp_th(cyc) || bt.stage !== 4'(stg(cyc)) || bt.busy !== 1'b1 || bt.done !== 1'b0) begin
                failures++;
                $display("FAIL full_seq_c%0d: en=%h stage=%0d busy=%b done=%b, want %h/%0d/1/0", cyc, bt.opr_en, bt.stage, bt.busy, bt.done, exp_th(cyc), stg(cyc));
            end
            if (cyc == 70) drive(1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bt.done !== 1'b1 || bt.opr_en !== 8'h00 || bt.busy !== 1'b0 || bt.timeout_err !== 1'b0 || bo.done !== 1'b1) begin
            failures++;
            $display("FAIL full_done_c71: done=%b en=%h busy=%b terr=%b odone=%b, want 1/00/0/0/1", bt.done, bt.opr_en, bt.busy, bt.timeout_err, bo.done);
        end
        tick();
        checks++;
        if (bt.done !== 1'b0) begin
            failures++;
            $display("FAIL full_done_width: done=%b, want 0", bt.done);
        end
    endtask

    task automatic test_timeout();
        start();
        repeat (80) begin
            checks++;
            if (bt.opr_en !== exp_th(cyc) || bt.busy !== 1'b1 || bt.timeout_err !== 1'b0) begin
                failures++;
                $display("FAIL timeout_run_c%0d: en=%h busy=%b terr=%b, want %h/1/0", cyc, bt.opr_en, bt.busy, bt.timeout_err, exp_th(cyc));
            end
            tick();
        end
        checks++;
        if (bt.timeout_err !== 1'b1 || bt.done !== 1'b0 || bt.opr_en !== 8'h00 || bt.busy !== 1'b0 || bo.timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_c81: terr=%b done=%b en=%h busy=%b oterr=%b, want 1/0/00/0/1", bt.timeout_err, bt.done, bt.opr_en, bt.busy, bo.timeout_err);
        end
        tick();
        checks++;
        if (bt.timeout_err !== 1'b0 || bt.done !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse_width: terr=%b done=%b, want 0/0", bt.timeout_err, bt.done);
        end
    endtask

    task automatic test_onehot();
        start();
        repeat (64) begin
            checks++;
            if (bo.opr_en !== exp_oh(cyc) || bo.stage !== 4'(stg(cyc))) begin
                failures++;
                $display("FAIL onehot_c%0d: en=%h stage=%0d, want %h/%0d", cyc, bo.opr_en, bo.stage, exp_oh(cyc), stg(cyc));
            end
            tick();
        end
        checks++;
        if (bo.opr_en !== 8'h80 || bo.busy !== 1'b1) begin
            failures++;
            $display("FAIL onehot_wait_c65: en=%h busy=%b, want 80/1", bo.opr_en, bo.busy);
        end
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic seen;
        start();
        repeat (29) tick();
        drive(1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bt.opr_en !== 8'h00 || bt.busy !== 1'b0 || bt.done !== 1'b0 || bo.opr_en !== 8'h00) begin
            failures++;
            $display("FAIL abort_c31: en=%h busy=%b done=%b oen=%h, want 00/0/0/00", bt.opr_en, bt.busy, bt.done, bo.opr_en);
        end
        seen = 1'b0;
        repeat (100) begin
            tick();
            seen = seen | bt.done | bt.timeout_err | bt.busy;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet: activity=%b, want 0", seen);
        end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bt.busy !== 1'b0 || bt.opr_en !== 8'h00) begin
            failures++;
            $display("FAIL abort_over_valid: busy=%b en=%h, want 0/00", bt.busy, bt.opr_en);
        end
        start();
        repeat (69) tick();
        drive(1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bt.done !== 1'b0 || bt.busy !== 1'b0 || bt.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_over_finish: done=%b busy=%b terr=%b, want 0/0/0", bt.done, bt.busy, bt.timeout_err);
        end
    endtask

    task automatic test_ignore_in_run();
        start();
        repeat (70) begin
            checks++;
            if (bt.opr_en !== exp_th(cyc) || bt.busy !== 1'b1 || bt.done !== 1'b0) begin
                failures++;
                $display("FAIL ignore_c%0d: en=%h busy=%b done=%b, want %h/1/0", cyc, bt.opr_en, bt.busy, bt.done, exp_th(cyc));
            end
            drive(cyc == 20, 1'b0, cyc == 20 || cyc == 70);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bt.done !== 1'b1 || bt.busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_done_c71: done=%b busy=%b, want 1/0", bt.done, bt.busy);
        end
    endtask

    task automatic test_finish_vs_timeout();
        start();
        repeat (79) tick();
        drive(1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bt.done !== 1'b1 || bt.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL finish_wins: done=%b terr=%b, want 1/0", bt.done, bt.timeout_err);
        end
    endtask

    task automatic test_back_to_back();
        start();
        repeat (69) tick();
        drive(1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (bt.done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done: done=%b, want 1", bt.done);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0);
        checks++;
        if (bt.opr_en !== 8'h01 || bt.busy !== 1'b1 || bt.done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart: en=%h busy=%b done=%b, want 01/1/0", bt.opr_en, bt.busy, bt.done);
        end
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        start();
        repeat (39) tick();
        #2;
        rstb = 1'b0;
        #1;
        checks++;
        if (bt.opr_en !== 8'h00 || bt.busy !== 1'b0 || bt.stage !== 4'd0 || bt.done !== 1'b0 || bt.timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: en=%h busy=%b stage=%0d done=%b terr=%b, want 00/0/0/0/0", bt.opr_en, bt.busy, bt.stage, bt.done, bt.timeout_err);
        end
        @(negedge clk);
        rstb = 1'b1;
        tick(); tick();
        checks++;
        if (bt.busy !== 1'b0 || bt.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle: busy=%b done=%b, want 0/0", bt.busy, bt.done);
        end
        start();
        checks++;
        if (bt.opr_en !== 8'h01 || bt.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_restart: en=%h busy=%b, want 01/1", bt.opr_en, bt.busy);
        end
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_seq();
        test_timeout();
        test_onehot();
        test_abort();
        test_ignore_in_run();
        test_finish_vs_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_opr_seq.md
CACHE_OPR_SEQ -- requirements
Module: cache_opr_seq

Interface
REQ-001 SHALL have parameter NUM_OPR, default 8: number of sequenced cache operations, legal range 1-32.
REQ-002 SHALL have parameter STAGE_CYCLES, default 8: cycles each stage is held, minimum 1.
REQ-003 SHALL have parameter THERMO, default 1: 1 = cumulative enables, 0 = one-hot enables.
REQ-004 SHALL have parameter TIMEOUT, default 255: max WAIT_FIN cycles before error; 0 disables the timeout.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rstb, input, 1: one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port valid, input, 1: start request, sampled in IDLE only.
REQ-008 SHALL have port abort, input, 1: synchronous cancel of the sequence in progress.
REQ-009 SHALL have port opr_finished, input, 1: completion strobe from the last operation.
REQ-010 SHALL have port opr_en, output, NUM_OPR: operation enables, bit i drives operation i+1.
REQ-011 SHALL have port stage, output, $clog2(NUM_OPR)+1: current stage index.
REQ-012 SHALL have port busy, output, 1: high in RUN and WAIT_FIN.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port timeout_err, output, 1: one-cycle timeout pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and WAIT_FIN, plus a stage counter and a cycle timer; timer width is $clog2(max(STAGE_CYCLES,TIMEOUT))+1 bits, no wrap.
REQ-016 SHALL, in IDLE with valid=1, go to RUN with stage=0 and timer=0, so opr_en[0] asserts the cycle after valid is sampled (latency 1).
REQ-017 SHALL, in RUN, increment timer each cycle; at timer==STAGE_CYCLES-1, set stage+1 and timer=0 if stage<NUM_OPR-1, else go to WAIT_FIN with timer=0.
REQ-018 SHALL drive opr_en in RUN and WAIT_FIN as follows: THERMO=1 gives bits [stage:0] set; THERMO=0 gives only bit stage set.
REQ-019 SHALL drive opr_en=0 and stage=0 in IDLE.
REQ-020 SHALL, in WAIT_FIN, hold the last-stage opr_en and increment timer; opr_finished=1 returns to IDLE and pulses done in the first IDLE cycle.
REQ-021 SHALL, in WAIT_FIN with TIMEOUT!=0 and timer==TIMEOUT-1 without opr_finished, return to IDLE and pulse timeout_err in the first IDLE cycle.
REQ-022 SHALL let opr_finished win over timeout when both occur in the same cycle.
REQ-023 SHALL ignore opr_finished outside WAIT_FIN.
REQ-024 SHALL ignore valid outside IDLE, with no queueing; valid in a done/timeout_err pulse cycle starts a new sequence.
REQ-025 SHALL, on abort=1 in any state, enter IDLE the next cycle with opr_en=0 and no done or timeout_err pulse.
REQ-026 SHALL give abort priority over valid, opr_finished and timeout.
REQ-027 SHALL never assert done and timeout_err in the same cycle.
REQ-028 SHALL drive all outputs from registers or from decode of registered state only, with no combinational input-to-output path.

Reset
REQ-029 SHALL, while rstb=0, immediately force state=IDLE, stage=0, timer=0, opr_en=0, busy=0, done=0 and timeout_err=0.
REQ-030 SHALL, after rstb deasserts, remain in IDLE until valid is sampled high.
REQ-031 SHALL give reset mid-sequence no done or timeout_err pulse.

Verification (NUM_OPR=8, STAGE_CYCLES=8, TIMEOUT=16 unless stated)
REQ-032 SHALL cover: THERMO=1, valid at cycle 0 -> opr_en=0x01 cycles 1-8, 0x03 cycles 9-16, ..., 0xFF cycles 57-64, held 0xFF from cycle 65; opr_finished at cycle 70 -> done=1, opr_en=0x00, busy=0 in cycle 71.
REQ-033 SHALL cover: as REQ-032 with no opr_finished -> WAIT_FIN cycles 65-80, timeout_err=1 and opr_en=0 in cycle 81, done stays 0.
REQ-034 SHALL cover: THERMO=0, valid at cycle 0 -> opr_en=0x04 with stage=2 in cycles 17-24, and 0x80 from cycle 57.
REQ-035 SHALL cover: abort at cycle 30 -> opr_en=0, busy=0 in cycle 31, and no done or timeout_err ever.
REQ-036 SHALL cover: valid and opr_finished pulsed at cycle 20 during RUN -> no effect, sequence timing identical to REQ-032.
REQ-037 SHALL cover: rstb low at cycle 40 -> outputs 0 immediately; after release, valid restarts with opr_en=0x01 the next cycle.
